// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latencies count busy cycles after the start cycle; the counter is loaded with latency - 1.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  typedef enum logic [2:0] {
    HZ_NONE     = 3'd0,
    HZ_LOAD_USE = 3'd1,
    HZ_MD       = 3'd2,
    HZ_MEM      = 3'd3,
    HZ_EXCEPT   = 3'd4
  } hazard_e;

  localparam int MD_MULT_LAT = 4;
  localparam int MD_DIV_LAT  = 33;
  localparam int MEM_TIMEOUT = 64;
  localparam int MD_CNT_W    = 6;
  localparam int WDOG_W      = 6;

  function automatic logic [MD_CNT_W-1:0] md_load_value(input logic is_div);
    return is_div ? MD_CNT_W'(MD_DIV_LAT - 1) : MD_CNT_W'(MD_MULT_LAT - 1);
  endfunction

  // Highest-priority hazard wins; lower ones are ignored in the same cycle.
  function automatic hazard_e select_hazard(input logic except_valid,
                                            input logic mem_stall,
                                            input logic md_stall,
                                            input logic load_use);
    if (except_valid)   return HZ_EXCEPT;
    else if (mem_stall) return HZ_MEM;
    else if (md_stall)  return HZ_MD;
    else if (load_use)  return HZ_LOAD_USE;
    else                return HZ_NONE;
  endfunction

endpackage

// File: rtl/md_latency_counter.sv
// Mult/div latency down-counter: loaded on issue, counts down while active,
// flags the final busy cycle when it reaches zero.
module md_latency_counter
  import pipe_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [MD_CNT_W-1:0] load_val,
  input  logic                active,
  output logic                done
);

  logic [MD_CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (active && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign done = active && (count == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: resolves exception, memory wait, mult/div busy and
// load-use hazards into per-stage stall/flush controls, plus a memory-timeout watchdog.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic id_load_use,
  input  logic ex_md_start,
  input  logic ex_md_div,
  input  logic ex_hilo_use,
  input  logic mem_req,
  input  logic mem_ack,
  input  logic except_valid,
  output logic stall_if,
  output logic stall_id,
  output logic stall_ex,
  output logic stall_mem,
  output logic flush_ex,
  output logic flush_mem,
  output logic flush_wb,
  output logic flush_all,
  output logic md_busy,
  output logic md_done,
  output logic bus_err
);

  md_state_e         state;
  hazard_e           hazard;
  logic              busy;
  logic              md_last;
  logic              md_issue;
  logic              mem_stall;
  logic              md_stall;
  logic              wdog_count_en;
  logic              wdog_hit;
  logic [WDOG_W-1:0] wdog;

  assign busy      = (state == MD_BUSY);
  assign mem_stall = mem_req & ~mem_ack;
  assign md_stall  = busy & (ex_hilo_use | ex_md_start);
  // A start that is itself frozen by a memory stall or killed by an exception must not issue.
  assign md_issue  = (state == IDLE) & ex_md_start & ~except_valid & ~mem_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (md_issue) state <= MD_BUSY;
        MD_BUSY: if (md_last)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  md_latency_counter u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (md_issue),
    .load_val (md_load_value(ex_md_div)),
    .active   (busy),
    .done     (md_last)
  );

  assign wdog_count_en = mem_stall & ~except_valid;
  assign wdog_hit      = wdog_count_en & (wdog == WDOG_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog <= '0;
    end else if (!wdog_count_en || wdog_hit) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 1'b1;
    end
  end

  assign hazard = select_hazard(except_valid, mem_stall, md_stall, id_load_use);

  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    flush_all = 1'b0;
    if (!reset) begin
      case (hazard)
        HZ_EXCEPT: begin
          flush_all = 1'b1;
        end
        HZ_MEM: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          flush_wb  = 1'b1;
        end
        HZ_MD: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
        end
        HZ_LOAD_USE: begin
          stall_if = 1'b1;
          stall_id = 1'b1;
          flush_ex = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign md_busy = ~reset & busy;
  assign md_done = ~reset & md_last;
  assign bus_err = ~reset & wdog_hit;

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port id_load_use, input, 1 bit: ID instruction needs the result of a load currently in EX.
REQ-004 SHALL have port ex_md_start, input, 1 bit: EX instruction issues a mult/div.
REQ-005 SHALL have port ex_md_div, input, 1 bit: qualifies ex_md_start (1 = div, 0 = mult).
REQ-006 SHALL have port ex_hilo_use, input, 1 bit: EX instruction reads or writes HI/LO (mfhi/mflo/mthi/mtlo).
REQ-007 SHALL have port mem_req, input, 1 bit: MEM-stage load/store is active.
REQ-008 SHALL have port mem_ack, input, 1 bit: data memory completes the access this cycle.
REQ-009 SHALL have port except_valid, input, 1 bit: exception or eret committed in MEM this cycle.
REQ-010 SHALL have ports stall_if, stall_id, stall_ex, stall_mem, outputs, 1 bit each: hold the IF, IF/ID, ID/EX and EX/MEM registers.
REQ-011 SHALL have ports flush_ex, flush_mem, flush_wb, outputs, 1 bit each: insert a bubble into ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have port flush_all, output, 1 bit: clear every pipeline register.
REQ-013 SHALL have ports md_busy, md_done and bus_err, outputs, 1 bit each: mult/div unit occupied; one-cycle mult/div completion pulse; one-cycle memory timeout pulse.

Function
REQ-014 SHALL drive the stall and flush outputs combinationally from the current inputs and registered state, in the same cycle.
REQ-015 SHALL apply the following priority: except_valid > mem_stall > md_stall > id_load_use.
REQ-016 SHALL, on except_valid, assert flush_all and force every stall output to 0.
REQ-017 SHALL define mem_stall = mem_req & ~mem_ack; when it is active, stall_if/id/ex/mem SHALL be 1 and flush_wb SHALL be 1.
REQ-018 SHALL define md_stall = md_busy & (ex_hilo_use | ex_md_start); when it is active, stall_if/id/ex SHALL be 1 and flush_mem SHALL be 1.
REQ-019 SHALL, on id_load_use with no higher-priority condition, set stall_if and stall_id to 1 and flush_ex to 1.
REQ-020 SHALL use a two-state FSM, IDLE and MD_BUSY, with md_busy = (state == MD_BUSY).
REQ-021 SHALL move IDLE to MD_BUSY when ex_md_start is high and neither except_valid nor mem_stall is active, loading the 6-bit counter with 3 for mult or 32 for div.
REQ-022 SHALL, in MD_BUSY, decrement the counter every cycle regardless of stalls; at count 0 it SHALL pulse md_done for one cycle and return to IDLE, so md_busy lasts 4 cycles for mult and 33 for div after the start cycle.
REQ-023 SHALL let except_valid leave an in-flight mult/div running to completion.
REQ-024 SHALL treat ex_md_start in the md_done cycle as md_stall; the new start is accepted in the following cycle.
REQ-025 SHALL run a 6-bit watchdog that increments on every mem_stall cycle and clears on any other cycle.
REQ-026 SHALL, when the watchdog reaches 63 while mem_stall is active, pulse bus_err for one cycle and wrap the watchdog to 0; the stall continues.
REQ-027 SHALL clear the watchdog on except_valid.

Reset
REQ-028 SHALL, while reset=1, set the state to IDLE and clear the md counter and the watchdog.
REQ-029 SHALL, while reset=1, force md_busy, md_done, bus_err and all stall/flush outputs to 0.
REQ-030 SHALL, when reset asserts mid mult/div, abandon the operation with no md_done pulse.

Structure
REQ-031 SHALL place the FSM state enum and the constants MD_MULT_LAT=4, MD_DIV_LAT=33 and MEM_TIMEOUT=64 in the shared package pipe_ctrl_pkg.
REQ-032 SHALL implement the mult/div latency counter (load, decrement, done pulse) as the sub-module md_latency_counter.

Verification
REQ-033 SHALL cover: id_load_use=1 for 1 cycle -> stall_if=stall_id=flush_ex=1 that cycle only; all else 0.
REQ-034 SHALL cover: ex_md_start with ex_md_div=1, then ex_hilo_use held -> md_busy for 33 cycles, stall_if/id/ex and flush_mem for 33 cycles, md_done at cycle 33, stall drop in cycle 34.
REQ-035 SHALL cover: mem_req=1 with mem_ack=0 for 5 cycles, then ack -> stall_if/id/ex/mem and flush_wb for exactly 5 cycles; bus_err never asserts.
REQ-036 SHALL cover: mem_req=1 with mem_ack=0 for 70 cycles -> a single bus_err pulse on the 64th stall cycle, with stalls held throughout.
REQ-037 SHALL cover: except_valid during a mem_stall while a mult is busy -> flush_all=1 with all stalls 0 that cycle, the watchdog cleared, and the mult still producing md_done on schedule.
REQ-038 SHALL cover: reset=1 asserted in the 10th cycle of a div -> outputs 0 the next cycle, md_busy=0, and no md_done pulse.
